// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift unit.
//   shift_op_e    : 3-bit operation code (PASS/SLL/SRL/SRA/ROL/ROR; 6 and 7 reserved)
//   shift_state_e : control FSM states (IDLE/SHIFT/DONE)
//   is_shift_op() : true for codes that actually move bits (SLL..ROR)
package shift_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_SLL  = 3'd1,
        OP_SRL  = 3'd2,
        OP_SRA  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

    function automatic logic is_shift_op(input logic [2:0] code);
        return (code >= 3'd1) && (code <= 3'd5);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves a DATA_WIDTH word by amt_i bits
// according to op_i. amt_i may equal DATA_WIDTH (rotates then return the
// input unchanged, logical shifts return zero).
//   data_i : operand
//   op_i   : shift_op_e code; PASS and reserved codes pass data through
//   amt_i  : shift distance, 0..DATA_WIDTH
//   data_o : shifted word
module shift_step
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int AMT_W      = 6
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [2:0]            op_i,
    input  logic [AMT_W-1:0]      amt_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    // Complementary distance for rotates; with amt_i==0 the opposite shift is
    // by the full width and contributes nothing.
    logic [AMT_W-1:0] inv_amt;
    assign inv_amt = AMT_W'(DATA_WIDTH) - amt_i;

    always_comb begin
        data_o = data_i;
        case (op_i)
            OP_SLL:  data_o = data_i << amt_i;
            OP_SRL:  data_o = data_i >> amt_i;
            OP_SRA:  data_o = DATA_WIDTH'($signed(data_i) >>> amt_i);
            OP_ROL:  data_o = (data_i << amt_i) | (data_i >> inv_amt);
            OP_ROR:  data_o = (data_i >> amt_i) | (data_i << inv_amt);
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/multicycle_shift_unit.sv
// Multi-cycle shift/rotate unit. One operand is accepted, then shifted by up
// to STEP bits per clock until the requested amount is consumed; the result
// is then offered on the result channel.
//   clk, rst (async, active low), flush (sync abort)
//   op_valid/op_ready, op_code, op_shamt, op_data : request channel
//   res_valid/res_ready, res_data                 : result channel
//   dbg_state                                     : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid never depends on ready; the requester holds its payload
// until accepted, and res_data is held stable while res_valid is high and
// res_ready is low. flush wins over both channels in the same cycle.
module multicycle_shift_unit
    import shift_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int STEP       = 4,
    localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_code,
    input  logic [SHAMT_W-1:0]    op_shamt,
    input  logic [DATA_WIDTH-1:0] op_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [1:0]            dbg_state
);

    // One extra bit so STEP itself (up to DATA_WIDTH) is representable.
    localparam int              REM_W  = SHAMT_W + 1;
    localparam logic [REM_W-1:0] STEP_R = REM_W'(STEP);

    shift_state_e          state_q, state_d;
    shift_op_e             op_q, op_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [REM_W-1:0]      step_amt;
    logic [DATA_WIDTH-1:0] step_out;
    logic                  accept;

    assign step_amt  = (rem_q > STEP_R) ? STEP_R : rem_q;
    assign op_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & res_ready);
    assign accept    = op_valid & op_ready & ~flush;
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = data_q;
    assign dbg_state = state_q;

    shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .AMT_W      (REM_W)
    ) u_step (
        .data_i (data_q),
        .op_i   (op_q),
        .amt_i  (step_amt),
        .data_o (step_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        if (flush) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    data_d = step_out;
                    rem_d  = rem_q - step_amt;
                    if (rem_q <= STEP_R) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
            // accept is only possible in IDLE or a consumed DONE, so it
            // never competes with the SHIFT update above.
            if (accept) begin
                data_d = op_data;
                op_d   = shift_op_e'(op_code);
                if ((op_shamt == '0) || !is_shift_op(op_code)) begin
                    state_d = ST_DONE;
                    rem_d   = '0;
                end else begin
                    state_d = ST_SHIFT;
                    rem_d   = {1'b0, op_shamt};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_PASS;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_multicycle_shift_unit.sv
// Directed bench for multicycle_shift_unit (DATA_WIDTH=32, STEP=4).
module tb_multicycle_shift_unit;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_code;
    logic [SW-1:0] op_shamt;
    logic [W-1:0]  op_data;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [2:0]   code;
        logic [SW-1:0] shamt;
        logic [W-1:0] data;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[15];

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    multicycle_shift_unit #(
        .DATA_WIDTH (W),
        .STEP       (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_shamt  (op_shamt),
        .op_data   (op_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the accept edge; cyc counts edges from the
    // accept edge (inclusive) until res_valid is observed.
    task automatic wait_res(input string name, input bit check_busy, output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 1;
        while (!seen && cyc <= 40) begin
            if (res_valid) begin
                seen = 1'b1;
            end else begin
                if (check_busy) check({name, " busy op_ready"}, {31'b0, op_ready}, 32'd0);
                tick();
                cyc++;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: res_valid not seen within 40 cycles", name);
        end
    endtask

    task automatic drive_op(input logic [2:0] code, input logic [SW-1:0] shamt, input logic [W-1:0] data);
        op_valid = 1'b1;
        op_code  = code;
        op_shamt = shamt;
        op_data  = data;
    endtask

    // Scramble request fields after accept: they must have no effect.
    task automatic scramble_op();
        op_valid = 1'b0;
        op_code  = 3'($urandom_range(0, 7));
        op_shamt = SW'($urandom_range(0, 31));
        op_data  = $urandom;
    endtask

    task automatic run_op(input logic [2:0] code, input logic [SW-1:0] shamt, input logic [W-1:0] data,
                          input logic [W-1:0] exp, input int lat, input string name);
        int cyc;
        bit seen;
        check({name, " op_ready idle"}, {31'b0, op_ready}, 32'd1);
        drive_op(code, shamt, data);
        exp_q.push_back(exp);
        tick();
        scramble_op();
        wait_res(name, 1'b1, cyc, seen);
        if (seen) begin
            check({name, " latency"}, 32'(cyc), 32'(lat));
            check({name, " data"}, res_data, exp_q[0]);
            exp_q.delete(0);
            tick();
            check({name, " consumed"}, {31'b0, res_valid}, 32'd0);
        end else begin
            exp_q.delete(0);
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
    endtask

    initial begin
        int  cyc;
        bit  seen;
        bit  rose;

        vecs[0]  = '{3'd1, 5'd5,  32'h0000_00F1, 32'h0000_1E20, 3};
        vecs[1]  = '{3'd3, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 9};
        vecs[2]  = '{3'd2, 5'd31, 32'h8000_0000, 32'h0000_0001, 9};
        vecs[3]  = '{3'd5, 5'd1,  32'h0000_0001, 32'h8000_0000, 2};
        vecs[4]  = '{3'd4, 5'd4,  32'h8000_0001, 32'h0000_0018, 2};
        vecs[5]  = '{3'd1, 5'd0,  32'h1234_5678, 32'h1234_5678, 1};
        vecs[6]  = '{3'd0, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        vecs[7]  = '{3'd6, 5'd9,  32'hCAFE_F00D, 32'hCAFE_F00D, 1};
        vecs[8]  = '{3'd3, 5'd8,  32'h8765_4321, 32'hFF87_6543, 3};
        vecs[9]  = '{3'd5, 5'd12, 32'h1234_5678, 32'h6781_2345, 4};
        vecs[10] = '{3'd4, 5'd16, 32'h1234_5678, 32'h5678_1234, 5};
        vecs[11] = '{3'd2, 5'd3,  32'hF000_0000, 32'h1E00_0000, 2};
        vecs[12] = '{3'd1, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 9};
        vecs[13] = '{3'd3, 5'd30, 32'h7FFF_FFFF, 32'h0000_0001, 9};
        vecs[14] = '{3'd4, 5'd31, 32'h0000_0001, 32'h8000_0000, 9};

        rst       = 1'b0;
        flush     = 1'b0;
        op_valid  = 1'b0;
        op_code   = 3'd0;
        op_shamt  = '0;
        op_data   = '0;
        res_ready = 1'b1;

        // reset values
        tick();
        tick();
        check("reset op_ready",  {31'b0, op_ready},  32'd1);
        check("reset res_valid", {31'b0, res_valid}, 32'd0);
        check("reset res_data",  res_data,           32'd0);
        check("reset state",     {30'b0, dbg_state}, 32'd0);
        rst = 1'b1;
        tick();

        // table-driven vectors
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].code, vecs[i].shamt, vecs[i].data, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // backpressure in DONE, then back-to-back accept
        res_ready = 1'b0;
        drive_op(3'd1, 5'd8, 32'h0000_0001);
        tick();
        scramble_op();
        wait_res("bp first", 1'b1, cyc, seen);
        check("bp first latency", 32'(cyc), 32'd3);
        drive_op(3'd2, 5'd4, 32'hABCD_0000);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp hold%0d data", i),      res_data,           32'h0000_0100);
            check($sformatf("bp hold%0d res_valid", i), {31'b0, res_valid}, 32'd1);
            check($sformatf("bp hold%0d op_ready", i),  {31'b0, op_ready},  32'd0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        check("bp release op_ready", {31'b0, op_ready}, 32'd1);
        tick();
        scramble_op();
        check("bp second state", {30'b0, dbg_state}, 32'd1);
        wait_res("bp second", 1'b1, cyc, seen);
        check("bp second latency", 32'(cyc), 32'd2);
        check("bp second data", res_data, 32'h0ABC_D000);
        tick();

        // flush mid-SHIFT with a competing request
        drive_op(3'd1, 5'd31, 32'hFFFF_FFFF);
        tick();
        scramble_op();
        tick();
        tick();
        flush = 1'b1;
        drive_op(3'd0, 5'd0, 32'h0000_0055);
        tick();
        flush    = 1'b0;
        op_valid = 1'b0;
        check("flush shift state",    {30'b0, dbg_state}, 32'd0);
        check("flush shift op_ready", {31'b0, op_ready},  32'd1);
        rose = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (res_valid) rose = 1'b1;
            tick();
        end
        check("flush shift no result", {31'b0, rose}, 32'd0);

        // flush in IDLE blocks a simultaneous accept
        flush = 1'b1;
        drive_op(3'd0, 5'd0, 32'h0000_0066);
        tick();
        flush    = 1'b0;
        op_valid = 1'b0;
        check("flush idle res_valid", {31'b0, res_valid}, 32'd0);
        check("flush idle state",     {30'b0, dbg_state}, 32'd0);

        // flush in DONE beats res_ready and a new request
        res_ready = 1'b0;
        drive_op(3'd0, 5'd0, 32'h0000_0077);
        tick();
        op_valid = 1'b0;
        check("flush done pre res_valid", {31'b0, res_valid}, 32'd1);
        flush     = 1'b1;
        res_ready = 1'b1;
        drive_op(3'd0, 5'd0, 32'h0000_0099);
        tick();
        flush    = 1'b0;
        op_valid = 1'b0;
        check("flush done res_valid", {31'b0, res_valid}, 32'd0);
        check("flush done state",     {30'b0, dbg_state}, 32'd0);
        tick();
        check("flush done stays idle", {31'b0, res_valid}, 32'd0);

        // asynchronous reset mid-SHIFT
        drive_op(3'd3, 5'd31, 32'h8000_0000);
        tick();
        scramble_op();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst mid res_valid", {31'b0, res_valid}, 32'd0);
        check("rst mid op_ready",  {31'b0, op_ready},  32'd1);
        check("rst mid res_data",  res_data,           32'd0);
        check("rst mid state",     {30'b0, dbg_state}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        run_op(3'd0, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, "post rst pass");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
